// File: rtl/uart_alu_cmd_seq.sv
// Command sequencer: parses SYNC/OPCODE/A/B[/CS] frames from the UART byte stream and runs one ALU op per frame.
// Optional checksum byte is enabled by defining UART_CMD_CHECKSUM_EN.
module uart_alu_cmd_seq #(
    parameter int          DATA_W         = 8,
    parameter int          OP_W           = 4,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int          MAX_OP         = 9,
    parameter int          TIMEOUT_CYCLES = 50000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [3:0]        alu_flags,
    input  logic              alu_done,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    output logic              alu_start,
    output logic [DATA_W-1:0] result,
    output logic [3:0]        result_flags,
    output logic              result_valid,
    output logic              busy,
    output logic              err_op,
    output logic              err_timeout,
    output logic              err_cs,
    output logic [7:0]        err_cnt
);

    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_GET_OP, S_GET_A, S_GET_B, S_GET_CS, S_EXEC, S_WAIT, S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [OP_W-1:0]   op_sh_q, op_sh_d;
    logic [7:0]        a_sh_q, a_sh_d, b_sh_q, b_sh_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [OP_W-1:0]   alu_op_q, alu_op_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [3:0]        flags_q, flags_d;
    logic              err_op_q, err_op_d, err_tmo_q, err_tmo_d;
    logic [7:0]        err_cnt_q, err_cnt_d;
    logic              in_get, op_legal, err_any;
`ifdef UART_CMD_CHECKSUM_EN
    logic              err_cs_q, err_cs_d, cs_ok;
    // Legal opcodes have a zero upper nibble, so the zero-extended shadow equals the received byte.
    assign cs_ok = (rx_data == (8'(op_sh_q) ^ a_sh_q ^ b_sh_q));
    assign err_any = err_op_d | err_tmo_d | err_cs_d;
    assign err_cs  = err_cs_q;
`else
    assign err_any = err_op_d | err_tmo_d;
    assign err_cs  = 1'b0;
`endif

    assign in_get   = (state_q == S_GET_OP) || (state_q == S_GET_A) ||
                      (state_q == S_GET_B)  || (state_q == S_GET_CS);
    assign op_legal = (rx_data[7:OP_W] == '0) && (32'(rx_data[OP_W-1:0]) <= MAX_OP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tmo_d     = '0;
        err_op_d  = 1'b0;
        err_tmo_d = 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
        err_cs_d  = 1'b0;
`endif
        case (state_q)
            S_IDLE:   if (rx_valid && rx_data == SYNC_BYTE) state_d = S_GET_OP;
            S_GET_OP: if (rx_valid) begin
                          if (op_legal) state_d = S_GET_A;
                          else begin
                              err_op_d = 1'b1;
                              state_d  = S_IDLE;
                          end
                      end
            S_GET_A:  if (rx_valid) state_d = S_GET_B;
`ifdef UART_CMD_CHECKSUM_EN
            S_GET_B:  if (rx_valid) state_d = S_GET_CS;
            S_GET_CS: if (rx_valid) begin
                          if (cs_ok) state_d = S_EXEC;
                          else begin
                              err_cs_d = 1'b1;
                              state_d  = S_IDLE;
                          end
                      end
`else
            S_GET_B:  if (rx_valid) state_d = S_EXEC;
`endif
            S_EXEC:   state_d = S_WAIT;
            S_WAIT:   if (alu_done) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        // A byte arriving on the terminal count wins over the timeout.
        if (in_get && !rx_valid) begin
            if (tmo_q == TMO_LAST) begin
                err_tmo_d = 1'b1;
                state_d   = S_IDLE;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    always_comb begin
        op_sh_d   = op_sh_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_op_d  = alu_op_q;
        result_d  = result_q;
        flags_d   = flags_q;
        err_cnt_d = err_cnt_q;
        if (rx_valid) begin
            case (state_q)
                S_GET_OP: op_sh_d = rx_data[OP_W-1:0];
                S_GET_A:  a_sh_d  = rx_data;
                S_GET_B:  b_sh_d  = rx_data;
                default:  ;
            endcase
        end
        // Shadow next-values are used so the final operand byte is visible in its own strobe cycle.
        if (state_d == S_EXEC && state_q != S_EXEC) begin
            alu_a_d  = DATA_W'(a_sh_d);
            alu_b_d  = DATA_W'(b_sh_d);
            alu_op_d = op_sh_d;
        end
        if (state_q == S_WAIT && alu_done) begin
            result_d = alu_result;
            flags_d  = alu_flags;
        end
        if (err_any && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_sh_q   <= '0;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_op_q  <= '0;
            result_q  <= '0;
            flags_q   <= '0;
            err_op_q  <= 1'b0;
            err_tmo_q <= 1'b0;
            err_cnt_q <= '0;
`ifdef UART_CMD_CHECKSUM_EN
            err_cs_q  <= 1'b0;
`endif
        end else begin
            op_sh_q   <= op_sh_d;
            a_sh_q    <= a_sh_d;
            b_sh_q    <= b_sh_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_op_q  <= alu_op_d;
            result_q  <= result_d;
            flags_q   <= flags_d;
            err_op_q  <= err_op_d;
            err_tmo_q <= err_tmo_d;
            err_cnt_q <= err_cnt_d;
`ifdef UART_CMD_CHECKSUM_EN
            err_cs_q  <= err_cs_d;
`endif
        end
    end

    always_comb begin
        alu_start    = (state_q == S_EXEC);
        result_valid = (state_q == S_DONE);
        busy         = (state_q != S_IDLE);
    end

    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign alu_op       = alu_op_q;
    assign result       = result_q;
    assign result_flags = flags_q;
    assign err_op       = err_op_q;
    assign err_timeout  = err_tmo_q;
    assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_uart_alu_cmd_seq.sv
// Bench for uart_alu_cmd_seq: directed frame table, random frames against a frame-level model, timeout and reset cases.
// Honours UART_CMD_CHECKSUM_EN the same way the design does.
module tb_uart_alu_cmd_seq;
  localparam int TMO = 1000;
  localparam int MAX_OP = 9;
  localparam logic [7:0] SYNC = 8'hA5;
`ifdef UART_CMD_CHECKSUM_EN
  localparam int CS_KIND = 2;
`else
  localparam int CS_KIND = 0;
`endif

  logic clk, rst_n;
  logic [7:0] rx_data;
  logic rx_valid;
  logic [7:0] alu_result;
  logic [3:0] alu_flags;
  logic alu_done;
  logic [7:0] alu_a, alu_b, result, err_cnt;
  logic [3:0] alu_op, result_flags;
  logic alu_start, result_valid, busy, err_op, err_timeout, err_cs;

  uart_alu_cmd_seq #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .alu_result(alu_result), .alu_flags(alu_flags), .alu_done(alu_done),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
    .result(result), .result_flags(result_flags), .result_valid(result_valid),
    .busy(busy), .err_op(err_op), .err_timeout(err_timeout), .err_cs(err_cs),
    .err_cnt(err_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] op, a, b, cs_x, r, g0, g1;
    logic [3:0] f;
    int lat, gap, op_gap, ng;
    bit noise, early;
    int kind;
  } vec_t;

  int checks = 0, errors = 0;
  int exp_starts = 0, exp_rvs = 0, exp_err_pulses = 0, exp_errs = 0;
  int n_start = 0, n_rv = 0, n_errp = 0;
  logic [7:0] last_a = 0, last_b = 0;
  logic [3:0] last_op = 0;
  logic [11:0] exp_q[$];
  logic [11:0] sb_e;
  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: every result_valid must match the oldest result the ALU model produced
  always @(negedge clk) begin
    if (rst_n) begin
      n_start = n_start + (alu_start ? 1 : 0);
      n_rv    = n_rv + (result_valid ? 1 : 0);
      n_errp  = n_errp + (err_op ? 1 : 0) + (err_timeout ? 1 : 0) + (err_cs ? 1 : 0);
      if (result_valid) begin
        if (exp_q.size() == 0) chk("rv_unexpected", 32'd1, 32'd0);
        else begin
          sb_e = exp_q.pop_front();
          chk("sb_result", {20'd0, result_flags, result}, {20'd0, sb_e});
        end
      end
    end
  end

  function automatic vec_t row(input logic [7:0] op, a, b, cs_x, r, input logic [3:0] f,
                               input int lat, ng, kind);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.cs_x = cs_x; v.r = r; v.f = f;
    v.lat = lat; v.ng = ng; v.kind = kind;
    v.gap = 1; v.op_gap = 1; v.g0 = 8'h33; v.g1 = 8'h7E;
    v.noise = 1'b0; v.early = 1'b0;
    return v;
  endfunction

  // frame-level reference: what the sequencer must do with a whole frame
  function automatic int model_kind(input vec_t v);
    if (v.op > 8'(MAX_OP)) return 1;
`ifdef UART_CMD_CHECKSUM_EN
    if (v.cs_x != 8'h00) return 2;
`endif
    return 0;
  endfunction

  task automatic note_err();
    exp_err_pulses++;
    if (exp_errs < 255) exp_errs++;
  endtask

  // driver tasks (enter and leave on a negedge)
  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) @(negedge clk);
    rx_data = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic chk_held(input string tag);
    chk({tag, "_alu_a_held"}, alu_a, last_a);
    chk({tag, "_alu_b_held"}, alu_b, last_b);
    chk({tag, "_alu_op_held"}, alu_op, last_op);
    chk({tag, "_no_start"}, alu_start, 0);
  endtask

  task automatic chk_all_zero();
    chk("rst_alu_a", alu_a, 0);          chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_op", alu_op, 0);        chk("rst_alu_start", alu_start, 0);
    chk("rst_result", result, 0);        chk("rst_result_flags", result_flags, 0);
    chk("rst_result_valid", result_valid, 0); chk("rst_busy", busy, 0);
    chk("rst_err_op", err_op, 0);        chk("rst_err_timeout", err_timeout, 0);
    chk("rst_err_cs", err_cs, 0);        chk("rst_err_cnt", err_cnt, 0);
  endtask

  // called in the EXEC cycle; plays the ALU and checks the result handshake
  task automatic run_exec(input vec_t v);
    chk("alu_start", alu_start, 1);
    chk("busy_exec", busy, 1);
    for (int i = 0; i < v.lat; i++) begin
      alu_done = (i == 0) && v.early;
      alu_result = ~v.r;
      rx_valid = v.noise;
      rx_data = SYNC;
      @(negedge clk);
      alu_done = 1'b0;
      rx_valid = 1'b0;
      chk("start_once", alu_start, 0);
      chk("no_rv_in_wait", result_valid, 0);
      chk("busy_wait", busy, 1);
    end
    alu_done = 1'b1;
    alu_result = v.r;
    alu_flags = v.f;
    rx_valid = v.noise;
    rx_data = SYNC;
    exp_q.push_back({v.f, v.r});
    exp_rvs++;
    @(negedge clk);
    alu_done = 1'b0;
    rx_valid = v.noise;
    chk("result_valid", result_valid, 1);
    chk("result", result, v.r);
    chk("result_flags", result_flags, v.f);
    @(negedge clk);
    rx_valid = 1'b0;
    chk("rv_pulse", result_valid, 0);
    chk("busy_after_done", busy, 0);
  endtask

  task automatic do_frame(input vec_t v, input int kind);
    if (v.ng > 0) send_byte(v.g0, v.gap);
    if (v.ng > 1) send_byte(v.g1, v.gap);
    if (v.ng > 0) chk("garbage_idle", busy, 0);
    send_byte(SYNC, v.gap);
    chk("busy_sync", busy, 1);
    send_byte(v.op, v.op_gap);
    chk("no_timeout", err_timeout, 0);
    if (kind == 1) begin
      chk("err_op", err_op, 1);
      chk("busy_err_op", busy, 0);
      note_err();
      @(negedge clk);
      chk("err_op_pulse", err_op, 0);
      chk_held("op");
      return;
    end
    chk("busy_op", busy, 1);
    send_byte(v.a, v.gap);
    send_byte(v.b, v.gap);
`ifdef UART_CMD_CHECKSUM_EN
    send_byte(v.op ^ v.a ^ v.b ^ v.cs_x, v.gap);
    if (kind == 2) begin
      chk("err_cs", err_cs, 1);
      chk("busy_err_cs", busy, 0);
      note_err();
      @(negedge clk);
      chk("err_cs_pulse", err_cs, 0);
      chk_held("cs");
      return;
    end
`endif
    chk("alu_a", alu_a, v.a);
    chk("alu_b", alu_b, v.b);
    chk("alu_op", alu_op, v.op[3:0]);
    last_a = v.a; last_b = v.b; last_op = v.op[3:0];
    exp_starts++;
    run_exec(v);
  endtask

  initial begin
    vec_t v;
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    alu_result = 8'h00; alu_flags = 4'h0; alu_done = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero();
    rst_n = 1'b1;
    @(negedge clk);

    tbl[0] = row(8'h02, 8'h0F, 8'h03, 8'h00, 8'd12, 4'h0, 2, 0, 0);
    tbl[1] = row(8'h01, 8'h05, 8'h06, 8'h00, 8'h0B, 4'h1, 1, 2, 0);
    tbl[2] = row(8'h0C, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0, 1, 0, 1);
    tbl[3] = row(8'h00, 8'h01, 8'h01, 8'h00, 8'h02, 4'h2, 3, 0, 0);
    tbl[4] = row(8'h09, 8'hFF, 8'hFF, 8'h00, 8'hFE, 4'hA, 4, 0, 0);
    tbl[5] = row(8'h0A, 8'h11, 8'h22, 8'h00, 8'h00, 4'h0, 1, 1, 1);
    tbl[6] = row(8'h10, 8'h11, 8'h22, 8'h00, 8'h00, 4'h0, 1, 0, 1);
    tbl[7] = row(8'h02, 8'h0F, 8'h03, 8'hF1, 8'h5A, 4'h5, 2, 0, CS_KIND);
    tbl[3].noise = 1'b1;
    tbl[3].early = 1'b1;
    tbl[3].gap = 0;
    for (int i = 0; i < 8; i++) begin
      do_frame(tbl[i], tbl[i].kind);
      chk("tbl_err_cnt", err_cnt, exp_errs);
    end

    // inter-byte timeout at the terminal count
    send_byte(SYNC, 0);
    send_byte(8'h03, 0);
    repeat (TMO - 1) @(negedge clk);
    chk("tmo_early", err_timeout, 0);
    chk("tmo_busy_before", busy, 1);
    @(negedge clk);
    chk("err_timeout", err_timeout, 1);
    chk("tmo_busy_after", busy, 0);
    note_err();
    @(negedge clk);
    chk("tmo_pulse", err_timeout, 0);
    chk_held("tmo");
    chk("tmo_err_cnt", err_cnt, exp_errs);

    // a byte landing on the terminal count is accepted
    v = row(8'h03, 8'h21, 8'h43, 8'h00, 8'h64, 4'h3, 2, 0, 0);
    v.op_gap = TMO - 1;
    do_frame(v, 0);

    // random frames against the frame-level model
    for (int n = 0; n < 60; n++) begin
      v = row(8'($urandom_range(0, MAX_OP)), 8'($urandom), 8'($urandom), 8'h00,
              8'($urandom), 4'($urandom), $urandom_range(1, 4), $urandom_range(0, 2), 0);
      if ($urandom_range(0, 3) == 0) v.op = 8'($urandom);
      if ($urandom_range(0, 4) == 0) v.cs_x = 8'($urandom_range(1, 255));
      do v.g0 = 8'($urandom); while (v.g0 == SYNC);
      do v.g1 = 8'($urandom); while (v.g1 == SYNC);
      v.gap = $urandom_range(0, 3);
      v.op_gap = v.gap;
      v.noise = 1'($urandom);
      v.early = 1'($urandom);
      do_frame(v, model_kind(v));
      chk("rand_err_cnt", err_cnt, exp_errs);
    end

    // reset while waiting for the ALU
    send_byte(SYNC, 0);
    send_byte(8'h03, 0);
    send_byte(8'h44, 0);
    send_byte(8'h55, 0);
`ifdef UART_CMD_CHECKSUM_EN
    send_byte(8'h03 ^ 8'h44 ^ 8'h55, 0);
`endif
    chk("rst_frame_start", alu_start, 1);
    chk("rst_frame_a", alu_a, 8'h44);
    exp_starts++;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_all_zero();
    last_a = 0; last_b = 0; last_op = 0; exp_errs = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_frame(row(8'h04, 8'h0F, 8'h03, 8'h00, 8'h77, 4'h8, 2, 0, 0), 0);
    chk("post_rst_err_cnt", err_cnt, exp_errs);

    // err_cnt saturation
    for (int n = 0; n < 260; n++) begin
      v = row(8'h0F, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0, 1, 0, 0);
      v.gap = 0;
      v.op_gap = 0;
      do_frame(v, model_kind(v));
    end
    chk("err_cnt_sat", err_cnt, exp_errs);

    repeat (3) @(negedge clk);
    chk("total_starts", n_start, exp_starts);
    chk("total_result_valid", n_rv, exp_rvs);
    chk("total_err_pulses", n_errp, exp_err_pulses);
    chk("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
